// File: rtl/hazard_unit.sv
// Decode-stage hazard/sequencing controller: load-use stall, redirect squash,
// ebreak halt, and saturating stall/flush performance counters.
module hazard_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic [2:0]  wb_jjee,
    input  logic        wb_valid,
    input  logic        resume,
    output logic        stall,
    output logic        jumpp,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [2:0] JJEE_EBREAK = 3'b010;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t     state, state_n;
    logic [3:0] fcnt, fcnt_n;
    logic       ld_haz;
    logic       brk;
    logic       run_stall;

    assign ld_haz = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign brk = wb_valid && (wb_jjee == JJEE_EBREAK);

    // A redirect wins over load-use, and a retiring ebreak suppresses the bubble
    // since the pipeline is about to halt anyway.
    assign run_stall = ld_haz && !ex_redirect && !brk;

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        case (state)
            RUN: begin
                if (brk) begin
                    state_n = HALT;
                    fcnt_n  = 4'd0;
                end else if (ex_redirect && (FLUSH_CYCLES > 1)) begin
                    state_n = FLUSH;
                    fcnt_n  = FCNT_RELOAD;
                end
            end
            FLUSH: begin
                if (brk) begin
                    state_n = HALT;
                    fcnt_n  = 4'd0;
                end else if (ex_redirect) begin
                    fcnt_n  = FCNT_RELOAD;
                end else if (fcnt <= 4'd1) begin
                    state_n = RUN;
                    fcnt_n  = 4'd0;
                end else begin
                    fcnt_n  = fcnt - 4'd1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                fcnt_n  = 4'd0;
            end
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        jumpp      = 1'b0;
        ifid_flush = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        case (state)
            RUN: begin
                jumpp      = ex_redirect;
                ifid_flush = ex_redirect;
                stall      = run_stall;
                pc_write   = !run_stall;
                ifid_write = !run_stall;
            end
            FLUSH: begin
                jumpp      = 1'b1;
                ifid_flush = 1'b1;
            end
            HALT: begin
                stall      = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
            default: ;
        endcase
        // Reset holds the front end frozen and squashing whatever is fetched.
        if (rst) begin
            stall      = 1'b0;
            jumpp      = 1'b1;
            ifid_flush = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            fcnt   <= 4'd0;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            fcnt   <= fcnt_n;
            halted <= (state_n == HALT);
        end
    end

    // HALT also drives stall high, but only load-use bubbles are counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if ((state == RUN) && stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (jumpp) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule
